// File: rtl/i2s_playback.sv
// rtl/i2s_playback.sv - byte stream to I2S master playback path
// Reassembles 3-byte LSB-first samples, drops sync words, buffers them and plays each mono sample on both I2S slots.
module i2s_playback #(
  parameter int                    DATA_SIZE           = 24,
  parameter int                    CLK_FREQ            = 100_000_000,
  parameter int                    I2S_CLK_FREQ        = 1_500_000,
  parameter int                    SAMPLE_FIFO_DEPTH   = 16,
  parameter logic [DATA_SIZE-1:0]  SYNC_WORD           = 24'hAAFF00,
  parameter int                    SIZE_UNDERRUN_COUNT = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [7:0]                           byte_in,
  input  logic                                 byte_valid,
  output logic                                 byte_ready,
  output logic                                 i2s_clk,
  output logic                                 i2s_ws,
  output logic                                 i2s_sd,
  output logic [$clog2(SAMPLE_FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                           sync_count,
  output logic [SIZE_UNDERRUN_COUNT-1:0]       underrun_count
);

  localparam int HALF  = CLK_FREQ / (2 * I2S_CLK_FREQ);
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int AW    = $clog2(SAMPLE_FIFO_DEPTH);

  typedef enum logic [1:0] {B0, B1, B2} asm_state_t;

  asm_state_t                     state_q, state_d;
  logic [15:0]                    lo_q, lo_d;
  logic [7:0]                     sync_q, sync_d;
  logic [AW:0]                    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_SIZE-1:0]           mem_q [SAMPLE_FIFO_DEPTH];
  logic [DIV_W-1:0]               div_q, div_d;
  logic                           clk_q, clk_d, ws_q, ws_d, sd_q, sd_d;
  logic [5:0]                     bit_q, bit_d;
  logic [DATA_SIZE-1:0]           play_q, play_d;
  logic [SIZE_UNDERRUN_COUNT-1:0] under_q, under_d;

  logic                 fifo_full, fifo_empty, fire, push, pop;
  logic [DATA_SIZE-1:0] word;
  logic [4:0]           slot_p, bit_idx;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign fifo_full  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
  assign fifo_empty = (wptr_q == rptr_q);
  assign byte_ready = !fifo_full;
  assign fire       = byte_valid && byte_ready;
  assign word       = {byte_in, lo_q};
  assign push       = fire && (state_q == B2) && (word != SYNC_WORD);

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    sync_d  = sync_q;
    div_d   = div_q + DIV_W'(1);
    clk_d   = clk_q;
    bit_d   = bit_q;
    ws_d    = ws_q;
    sd_d    = sd_q;
    play_d  = play_q;
    under_d = under_q;
    pop     = 1'b0;
    slot_p  = 5'd0;
    bit_idx = 5'd0;

    if (fire) begin
      case (state_q)
        B0: begin
          lo_d[7:0] = byte_in;
          state_d   = B1;
        end
        B1: begin
          lo_d[15:8] = byte_in;
          state_d    = B2;
        end
        default: begin
          if (word == SYNC_WORD) sync_d = sync_q + 8'd1;
          state_d = B0;
        end
      endcase
    end

    if (div_q == DIV_W'(HALF - 1)) begin
      div_d = '0;
      clk_d = !clk_q;
      // Falling edge of the bit clock: advance the frame and drive ws/sd in the same cycle.
      if (clk_q) begin
        bit_d = bit_q + 6'd1;
        if (bit_d == 6'd0) begin
          if (!fifo_empty) begin
            pop    = 1'b1;
            play_d = mem_q[rptr_q[AW-1:0]];
          end else begin
            play_d = '0;
            if (under_q != '1) under_d = under_q + SIZE_UNDERRUN_COUNT'(1);
          end
        end
        ws_d   = bit_d[5];
        slot_p = bit_d[4:0];
        sd_d   = 1'b0;
        // Slot bit 0 is the Philips one-bit delay; sample occupies positions 1..24 MSB first.
        if (slot_p >= 5'd1 && slot_p <= 5'd24) begin
          bit_idx = 5'd24 - slot_p;
          sd_d    = play_d[bit_idx];
        end
      end
    end

    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= B0;
      lo_q    <= '0;
      sync_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      div_q   <= '0;
      clk_q   <= 1'b0;
      bit_q   <= 6'd63;
      ws_q    <= 1'b0;
      sd_q    <= 1'b0;
      play_q  <= '0;
      under_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      sync_q  <= sync_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      div_q   <= div_d;
      clk_q   <= clk_d;
      bit_q   <= bit_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
      play_q  <= play_d;
      under_q <= under_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SAMPLE_FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q[AW-1:0]] <= word;
    end
  end

  assign i2s_clk        = clk_q;
  assign i2s_ws         = ws_q;
  assign i2s_sd         = sd_q;
  assign fifo_level     = wptr_q - rptr_q;
  assign sync_count     = sync_q;
  assign underrun_count = under_q;

endmodule

// File: tb/tb_i2s_playback.sv
// tb/tb_i2s_playback.sv - directed bench for i2s_playback
// u_dut uses a one-cycle half period for fast frames; u_dut_def keeps defaults for bit-clock timing.
module tb_i2s_playback;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;

  logic       byte_ready, i2s_clk, i2s_ws, i2s_sd;
  logic [4:0] fifo_level;
  logic [7:0] sync_count, underrun_count;

  logic       d_ready, d_clk, d_ws, d_sd;
  logic [4:0] d_level;
  logic [7:0] d_sync, d_under;

  int vectors = 0;
  int miscompares = 0;

  i2s_playback #(.CLK_FREQ(3_000_000), .I2S_CLK_FREQ(1_500_000)) u_dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .i2s_clk(i2s_clk), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd), .fifo_level(fifo_level),
    .sync_count(sync_count), .underrun_count(underrun_count)
  );

  i2s_playback u_dut_def (
    .clk(clk), .rst_n(rst_n), .byte_in(8'h00), .byte_valid(1'b0), .byte_ready(d_ready),
    .i2s_clk(d_clk), .i2s_ws(d_ws), .i2s_sd(d_sd), .fifo_level(d_level),
    .sync_count(d_sync), .underrun_count(d_under)
  );

  always #5 clk = ~clk;

  // Bench-side bit counter, advanced on every observed falling edge of the fast instance's bit clock.
  int         fall_cnt = 0;
  logic [5:0] bit_m = 6'd63;
  logic       prev_clk = 1'b0;
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      bit_m    = 6'd63;
      prev_clk = 1'b0;
    end else begin
      if (prev_clk && !i2s_clk) begin
        bit_m = bit_m + 6'd1;
        fall_cnt++;
      end
      prev_clk = i2s_clk;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, want bench completion");
    $fatal(1, "watchdog expired");
  end

  task automatic next_fall();
    int c;
    c = fall_cnt;
    wait (fall_cnt != c);
  endtask

  task automatic wait_bit(input logic [5:0] b);
    do next_fall(); while (bit_m != b);
  endtask

  task automatic align_early();
    wait_bit(6'd1);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready) @(negedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [23:0] s);
    send_byte(s[7:0]);
    send_byte(s[15:8]);
    send_byte(s[23:16]);
  endtask

  task automatic capture_frame(output logic [31:0] l, output logic [31:0] r,
                               output int ws_bad, output logic [4:0] lvl0);
    int idx;
    l = '0; r = '0; ws_bad = 0;
    wait_bit(6'd0);
    lvl0 = fifo_level;
    for (int k = 0; k < 64; k++) begin
      if (k != 0) next_fall();
      idx = 31 - int'(bit_m[4:0]);
      if (!bit_m[5]) l[idx] = i2s_sd;
      else           r[idx] = i2s_sd;
      if (i2s_ws !== bit_m[5]) ws_bad++;
    end
  endtask

  task automatic test_reset();
    int   rise1 = 0, rise2 = 0, fall1 = 0, wsr = 0, wsf = 0;
    logic pc = 1'b0, pw = 1'b0, sd_seen = 1'b0;
    logic [7:0] u1 = 8'hxx;
    repeat (3) @(negedge clk);
    vectors++;
    if ({i2s_clk, i2s_ws, i2s_sd, fifo_level, sync_count, underrun_count} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_fast: got %h want 0", {i2s_clk, i2s_ws, i2s_sd, fifo_level, sync_count, underrun_count});
    end
    vectors++;
    if ({d_clk, d_ws, d_sd, d_level, d_sync, d_under} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_def: got %h want 0", {d_clk, d_ws, d_sd, d_level, d_sync, d_under});
    end
    vectors++;
    if (byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", byte_ready);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 5000 && wsf == 0; n++) begin
      @(posedge clk);
      #1;
      if (d_clk && !pc) begin
        if (rise1 == 0) rise1 = n;
        else if (rise2 == 0) rise2 = n;
      end
      if (!d_clk && pc && fall1 == 0) begin
        fall1 = n;
        u1    = d_under;
      end
      if (d_ws && !pw) wsr = n;
      if (!d_ws && pw) wsf = n;
      if (d_sd) sd_seen = 1'b1;
      pc = d_clk;
      pw = d_ws;
    end
    vectors++;
    if (rise1 != 33) begin miscompares++; $display("FAIL first_rise: got %0d want 33", rise1); end
    vectors++;
    if (fall1 != 66) begin miscompares++; $display("FAIL first_frame: got %0d want 66", fall1); end
    vectors++;
    if (rise2 - rise1 != 66) begin miscompares++; $display("FAIL clk_period: got %0d want 66", rise2 - rise1); end
    vectors++;
    if (u1 !== 8'd1) begin miscompares++; $display("FAIL first_underrun: got %0d want 1", u1); end
    vectors++;
    if (wsr != 2178) begin miscompares++; $display("FAIL ws_rise: got %0d want 2178", wsr); end
    vectors++;
    if (wsf != 4290) begin miscompares++; $display("FAIL ws_fall: got %0d want 4290", wsf); end
    vectors++;
    if (sd_seen !== 1'b0) begin miscompares++; $display("FAIL idle_sd: got %b want 0", sd_seen); end
  endtask

  task automatic test_single();
    logic [31:0] l, r;
    int          wb;
    logic [4:0]  lv;
    logic [7:0]  ub;
    align_early();
    send_sample(24'h123456);
    vectors++;
    if (fifo_level !== 5'd1) begin miscompares++; $display("FAIL single_level: got %0d want 1", fifo_level); end
    ub = underrun_count;
    capture_frame(l, r, wb, lv);
    vectors++;
    if (lv !== 5'd0) begin miscompares++; $display("FAIL single_pop: got %0d want 0", lv); end
    vectors++;
    if (l !== 32'h091A2B00) begin miscompares++; $display("FAIL single_left: got %h want 091a2b00", l); end
    vectors++;
    if (r !== 32'h091A2B00) begin miscompares++; $display("FAIL single_right: got %h want 091a2b00", r); end
    vectors++;
    if (wb != 0) begin miscompares++; $display("FAIL single_ws: got %0d bad bits want 0", wb); end
    vectors++;
    if (underrun_count !== ub) begin miscompares++; $display("FAIL single_underrun: got %0d want %0d", underrun_count, ub); end
  endtask

  task automatic test_sync_drop();
    logic [31:0] l, r;
    int          wb;
    logic [4:0]  lv, max_lvl;
    logic [7:0]  seq [6];
    seq = '{8'h00, 8'hFF, 8'hAA, 8'h03, 8'h02, 8'h01};
    max_lvl = 5'd0;
    align_early();
    for (int i = 0; i < 6; i++) begin
      send_byte(seq[i]);
      if (fifo_level > max_lvl) max_lvl = fifo_level;
    end
    vectors++;
    if (sync_count !== 8'd1) begin miscompares++; $display("FAIL sync_count: got %0d want 1", sync_count); end
    vectors++;
    if (max_lvl !== 5'd1) begin miscompares++; $display("FAIL sync_level: got %0d want 1", max_lvl); end
    capture_frame(l, r, wb, lv);
    vectors++;
    if ({l, r} !== {32'h00810180, 32'h00810180}) begin
      miscompares++;
      $display("FAIL sync_play: got %h %h want 00810180 00810180", l, r);
    end
    capture_frame(l, r, wb, lv);
    vectors++;
    if ({l, r} !== 64'h0) begin miscompares++; $display("FAIL sync_not_played: got %h %h want 0 0", l, r); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ub;
    align_early();
    ub = underrun_count;
    fork
      begin
        for (int k = 1; k <= 17; k++) send_sample(24'(k));
      end
      begin
        wait (byte_ready === 1'b0);
        #1;
        vectors++;
        if (fifo_level !== 5'd16) begin miscompares++; $display("FAIL burst_full: got %0d want 16", fifo_level); end
        wait (byte_ready === 1'b1);
        #3;
        vectors++;
        if ({bit_m, fifo_level} !== {6'd0, 5'd15}) begin
          miscompares++;
          $display("FAIL burst_reopen: got bit %0d level %0d want bit 0 level 15", bit_m, fifo_level);
        end
      end
      begin
        logic [31:0] l, r, e;
        int          wb;
        logic [4:0]  lv;
        for (int k = 1; k <= 17; k++) begin
          capture_frame(l, r, wb, lv);
          e = {1'b0, 24'(k), 7'b0};
          vectors++;
          if ({l, r} !== {e, e}) begin
            miscompares++;
            $display("FAIL burst_frame%0d: got %h %h want %h %h", k, l, r, e, e);
          end
        end
      end
    join
    vectors++;
    if (underrun_count !== ub) begin miscompares++; $display("FAIL burst_lost: got %0d want %0d", underrun_count, ub); end
    vectors++;
    if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL burst_drain: got %0d want 0", fifo_level); end
  endtask

  task automatic test_underrun();
    int sd_bad = 0;
    for (int f = 0; f < 300; f++) begin
      for (int b = 0; b < 64; b++) begin
        next_fall();
        if (i2s_sd !== 1'b0) sd_bad++;
      end
    end
    vectors++;
    if (sd_bad != 0) begin miscompares++; $display("FAIL underrun_sd: got %0d set bits want 0", sd_bad); end
    vectors++;
    if (underrun_count !== 8'd255) begin miscompares++; $display("FAIL underrun_sat: got %0d want 255", underrun_count); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] l, r;
    int          wb;
    logic [4:0]  lv;
    align_early();
    send_sample(24'h556677);
    send_byte(8'hAA);
    send_byte(8'hBB);
    wait_bit(6'd40);
    @(negedge clk);
    vectors++;
    if ({i2s_ws, fifo_level} !== {1'b1, 5'd1}) begin
      miscompares++;
      $display("FAIL mid_before: got ws %b level %0d want ws 1 level 1", i2s_ws, fifo_level);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({i2s_clk, i2s_ws, i2s_sd, fifo_level, sync_count, underrun_count, byte_ready} !== 25'h1) begin
      miscompares++;
      $display("FAIL mid_reset: got %h want 1", {i2s_clk, i2s_ws, i2s_sd, fifo_level, sync_count, underrun_count, byte_ready});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    align_early();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    capture_frame(l, r, wb, lv);
    vectors++;
    if ({l, r} !== {32'h19910880, 32'h19910880}) begin
      miscompares++;
      $display("FAIL mid_replay: got %h %h want 19910880 19910880", l, r);
    end
    vectors++;
    if (underrun_count !== 8'd1) begin miscompares++; $display("FAIL mid_underrun: got %0d want 1", underrun_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sync_drop();
    test_back_to_back();
    test_underrun();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
